alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares one 64x64 signed add/multiply ALU (2-cycle pipeline, `completed` pulse) among NREQ requesters.
- Round-robin arbitration.
- Issues exactly one op per grant, with zero-opcode gaps so the ALU completion pulse is always valid.
- Returns the 128-bit result with the requester id over a valid/ready response channel. Sits between client engines and the ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, width of requester id (ceil log2 NREQ).
- TIMEOUT_CYC, 8, WAIT-state cycle limit; used only with ALU_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock, all state on posedge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  request valid per requester.
- req_ready  output  NREQ  one-hot grant/accept; request is taken when valid&ready.
- req_a  input  NREQ*64  signed operand A, requester i at [64i+63:64i].
- req_b  input  NREQ*64  signed operand B, same packing.
- req_op  input  NREQ*2  opcode, requester i at [2i+1:2i]: 0=nop, 1=add, 2=mul, 3=zero.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted when valid&ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_c  output  128  signed result.
- rsp_err  output  1  response was produced by timeout.
- alu_a  output  64  to ALU A.
- alu_b  output  64  to ALU B.
- alu_op  output  2  to ALU opCode.
- alu_c  input  128  from ALU C.
- alu_completed  input  1  from ALU completed.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0 (req_ready, rsp_*, alu_*, busy). FSM goes to IDLE, RR pointer to 0, holding registers to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - alu_op=0.
  - If any req_valid is high, grant the first valid index searching from the pointer upward, with wrap.
  - req_ready for the winner is high only in the accept cycle; it is combinational from req_valid, state and pointer.
  - On accept, capture A, B, op and id.
  - op!=0 -> ISSUE. op==0 -> RESP with rsp_c=0; the ALU is not touched.
- ISSUE: alu_a/alu_b = captured operands, alu_op = captured op, for exactly one cycle -> WAIT.
- WAIT:
  - alu_op=0; alu_a/alu_b hold their values.
  - On alu_completed=1, capture alu_c into rsp_c -> RESP.
  - With a conforming ALU, completed arrives in the 2nd WAIT cycle, i.e. 2 cycles after the ISSUE cycle.
- RESP:
  - rsp_valid=1; rsp_c/rsp_id/rsp_err are stable until rsp_ready.
  - On rsp_ready -> IDLE, pointer = id+1 mod NREQ, rsp_valid drops next cycle.
- req_ready is 0 in every state except IDLE; requests raised while busy wait.
- At most one transaction is in flight. Minimum occupancy is 4 cycles per ALU op (IDLE, ISSUE, WAIT, WAIT) plus RESP.
- alu_op is 0 in the cycle before every ISSUE, which guarantees the ALU completion-pulse precondition.
- Opcode 3: issued normally; rsp_c=0, returned by the ALU.
- A requester dropping req_valid before it is granted is legal; nothing is granted for it.
- Only one requester has req_ready high per cycle.
- Reset mid-operation (any state): immediate return to reset values. The in-flight request is discarded with no response; the requester must reissue. The ALU shares resetn and is flushed too.
- A stray alu_completed outside WAIT is ignored.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit WAIT counter clears on entry to WAIT.
  - If TIMEOUT_CYC WAIT cycles elapse without alu_completed, go to RESP with rsp_c=0 and rsp_err=1.
  - rsp_err clears when the response is accepted.
- Undefined: no counter; WAIT holds indefinitely; rsp_err is tied to 0.

Test Plan:
- req0 A=5, B=-3, op=1: alu_op=1 for exactly 1 cycle; completed 2 cycles later; rsp_id=0, rsp_c=2 sign-extended to 128 bits, rsp_err=0.
- All four valid at once with op=2, A=i+2, B=-7 (pointer 0): grants in order 0,1,2,3; rsp_c = -14, -21, -28, -35; a 5th request from req0 is granted after req3.
- req2 op=0: RESP one cycle after accept, rsp_c=0, rsp_id=2; alu_op stays 0 throughout.
- rsp_ready held low 5 cycles with req1 valid: rsp_valid/rsp_c/rsp_id stable; req_ready=0 throughout; req1 granted only after rsp_ready is sampled high.
- resetn pulsed low during WAIT of a mul: all outputs 0 immediately, no response emitted; next add A=1, B=1 returns rsp_c=2 normally.
- ALU model with completed forced 0, TIMEOUT_CYC=8: macro defined -> rsp_valid after 8 WAIT cycles with rsp_err=1, rsp_c=0. Macro undefined -> busy stays 1 and rsp_valid stays 0 for 100 cycles.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
// rtl/alu_rr_arbiter_if.sv - request, response and ALU signal bundle for alu_rr_arbiter
interface alu_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ*2-1:0]  req_op;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [127:0]       rsp_c;
  logic               rsp_err;

  logic [63:0]        alu_a;
  logic [63:0]        alu_b;
  logic [1:0]         alu_op;
  logic [127:0]       alu_c;
  logic               alu_completed;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_c, alu_completed,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, alu_a, alu_b, alu_op
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_c, alu_completed,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one 2-cycle add/mul ALU among NREQ requesters
// Optional WAIT timeout (rsp_err) is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              resetn,
  alu_rr_arbiter_if.slave   bus,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, id_q, grant_id;
  logic           any_valid;
  logic [63:0]    sel_a, sel_b;
  logic [1:0]     sel_op;
  logic [63:0]    alu_a_q, alu_b_q;
  logic [1:0]     alu_op_q;
  logic           rsp_valid_q;
  logic [127:0]   rsp_c_q;
  logic           rsp_err_q;
  logic           timeout_hit;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x, input int k);
    int s;
    s = int'(x) + k;
    if (s >= NREQ) s -= NREQ;
    return IDW'(s);
  endfunction

  // Scanning offsets high to low leaves the nearest valid index above ptr as winner.
  always_comb begin
    any_valid = |bus.req_valid;
    grant_id  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_inc(ptr, k)]) grant_id = wrap_inc(ptr, k);
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a  = bus.req_a[64*i +: 64];
        sel_b  = bus.req_b[64*i +: 64];
        sel_op = bus.req_op[2*i +: 2];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (resetn && state == IDLE && any_valid) bus.req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_valid) state_n = (sel_op != 2'd0) ? ISSUE : RESP;
      ISSUE:   state_n = WAIT;
      WAIT:    if (bus.alu_completed || timeout_hit) state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // alu_op defaults to zero every cycle, so it is high for the ISSUE cycle only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      id_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
    end else begin
      alu_op_q <= 2'd0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            id_q <= grant_id;
            if (sel_op != 2'd0) begin
              alu_a_q  <= sel_a;
              alu_b_q  <= sel_b;
              alu_op_q <= sel_op;
            end else begin
              rsp_c_q     <= '0;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.alu_completed) begin
            rsp_c_q     <= bus.alu_c;
            rsp_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            rsp_c_q     <= '0;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr         <= wrap_inc(id_q, 1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (state == WAIT && !bus.alu_completed && timeout_hit) rsp_err_q <= 1'b1;
      else if (state == RESP && bus.rsp_ready)                rsp_err_q <= 1'b0;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign rsp_err_q      = 1'b0;
  assign timeout_unused = (TIMEOUT_CYC > 0);
`endif

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != IDLE);
endmodule
